// File: rtl/pc_pkg.sv
// Shared opcode and PC-source encodings for the fetch-stage PC sequencer.
package pc_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_BGT  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_BLT  = 6'b001001;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_BNE  = 6'b001011;
  localparam logic [OPC_W-1:0] OP_JMP  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_CALL = 6'b001101;
  localparam logic [OPC_W-1:0] OP_RET  = 6'b001110;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'b00,
    SRC_JMP = 2'b01,
    SRC_BR  = 2'b10,
    SRC_RET = 2'b11
  } pc_src_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push on full overwrites the oldest entry.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned PC_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              din,
  output logic [PC_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [PTR_W-1:0] w_top_inc;

  // Depth is a power of two, so the pointer wraps naturally; on full the
  // incremented pointer lands on the oldest entry.
  assign w_top_inc = r_top + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (push) begin
      r_top <= w_top_inc;
      if (full) r_ovf   <= 1'b1;
      else      r_count <= r_count + CNT_W'(1);
    end else if (pop && !empty) begin
      r_top   <= r_top - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push && !reset) r_mem[w_top_inc] <= din;
  end

  assign top   = r_mem[r_top];
  assign count = r_count;
  assign full  = (r_count == CNT_W'(RAS_DEPTH));
  assign empty = (r_count == '0);
  assign ovf   = r_ovf;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with branch/jump/call/return next-PC selection.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned    PC_W      = 32,
  parameter int unsigned    OP_W      = 6,
  parameter int unsigned    PC_INC    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned    RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       valid,
  input  logic [OP_W-1:0]            op,
  input  logic                       zero,
  input  logic                       bgt,
  input  logic                       blt,
  input  logic [PC_W-1:0]            branch_target,
  input  logic [PC_W-1:0]            jump_target,
  output logic [PC_W-1:0]            pc,
  output logic [1:0]                 pc_src,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  logic [PC_W-1:0] r_pc;
  logic            r_unf;
  pc_src_e         w_src;
  logic [PC_W-1:0] w_pc_seq;
  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_ras_top;
  logic            w_is_bgt, w_is_blt, w_is_beq, w_is_bne;
  logic            w_is_jmp, w_is_call, w_is_ret;
  logic            w_push, w_pop, w_update;

  assign w_is_bgt  = (op == OP_W'(OP_BGT));
  assign w_is_blt  = (op == OP_W'(OP_BLT));
  assign w_is_beq  = (op == OP_W'(OP_BEQ));
  assign w_is_bne  = (op == OP_W'(OP_BNE));
  assign w_is_jmp  = (op == OP_W'(OP_JMP));
  assign w_is_call = (op == OP_W'(OP_CALL));
  assign w_is_ret  = (op == OP_W'(OP_RET));

  assign w_pc_seq = r_pc + PC_W'(PC_INC);
  assign w_update = !stall && !reset;

  // Priority-ordered source decision; a ret on an empty stack falls through.
  always_comb begin
    w_src = SRC_SEQ;
    if (valid) begin
      if      (w_is_beq && zero)            w_src = SRC_BR;
      else if (w_is_bne && !zero)           w_src = SRC_BR;
      else if (w_is_blt && blt)             w_src = SRC_BR;
      else if (w_is_bgt && bgt)             w_src = SRC_BR;
      else if (w_is_jmp || w_is_call)       w_src = SRC_JMP;
      else if (w_is_ret && !ras_empty)      w_src = SRC_RET;
    end
  end

  always_comb begin
    w_next_pc = w_pc_seq;
    case (w_src)
      SRC_JMP: w_next_pc = jump_target;
      SRC_BR:  w_next_pc = branch_target;
      SRC_RET: w_next_pc = w_ras_top;
      default: w_next_pc = w_pc_seq;
    endcase
  end

  assign w_push = w_update && valid && w_is_call;
  assign w_pop  = w_update && (w_src == SRC_RET);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_unf <= 1'b0;
    end else if (!stall) begin
      r_pc <= w_next_pc;
      if (valid && w_is_ret && ras_empty) r_unf <= 1'b1;
    end
  end

  return_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pc_seq),
    .top   (w_ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty),
    .ovf   (ras_ovf)
  );

  assign pc      = r_pc;
  assign pc_src  = w_src;
  assign ras_unf = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned PC_INC = 4;
  localparam int unsigned DEPTH  = 8;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk;
  logic        reset, stall, valid, zero, bgt, blt;
  logic [5:0]  op;
  logic [31:0] branch_target, jump_target, pc;
  logic [1:0]  pc_src;
  logic [3:0]  ras_count;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_unf;

  pc_sequencer #(
    .PC_W      (PC_W),
    .OP_W      (OP_W),
    .PC_INC    (PC_INC),
    .RESET_PC  (RST_PC),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .valid         (valid),
    .op            (op),
    .zero          (zero),
    .bgt           (bgt),
    .blt           (blt),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .pc            (pc),
    .pc_src        (pc_src),
    .ras_count     (ras_count),
    .ras_full      (ras_full),
    .ras_empty     (ras_empty),
    .ras_ovf       (ras_ovf),
    .ras_unf       (ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_src(input logic vld, input logic [5:0] o,
                                           input logic z, input logic gt, input logic lt);
    if (!vld) return 2'd0;
    if (o == OP_BEQ) return z  ? 2'd2 : 2'd0;
    if (o == OP_BNE) return !z ? 2'd2 : 2'd0;
    if (o == OP_BLT) return lt ? 2'd2 : 2'd0;
    if (o == OP_BGT) return gt ? 2'd2 : 2'd0;
    if (o == OP_JMP || o == OP_CALL) return 2'd1;
    if (o == OP_RET) return (m_ras.size() > 0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  // One instruction cycle: drive, check the decision, clock, update model, check state.
  task automatic step(input logic rst, input logic stl, input logic vld, input logic [5:0] o,
                      input logic z, input logic gt, input logic lt,
                      input logic [31:0] bt, input logic [31:0] jt);
    logic [1:0]  exp_src;
    logic [31:0] nxt;
    reset = rst; stall = stl; valid = vld; op = o;
    zero = z; bgt = gt; blt = lt; branch_target = bt; jump_target = jt;
    #1;
    exp_src = model_src(vld, o, z, gt, lt);
    chk("pc_src", 32'(pc_src), 32'(exp_src));
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc = RST_PC;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!stl) begin
      case (exp_src)
        2'd1:    nxt = jt;
        2'd2:    nxt = bt;
        2'd3:    nxt = m_ras.pop_back();
        default: nxt = m_pc + PC_INC;
      endcase
      if (vld && o == OP_CALL) begin
        m_ras.push_back(m_pc + PC_INC);
        if (m_ras.size() > DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      if (vld && o == OP_RET && exp_src == 2'd0) m_unf = 1'b1;
      m_pc = nxt;
    end
    chk("pc",        pc,                     m_pc);
    chk("ras_count", 32'(ras_count),         32'(m_ras.size()));
    chk("ras_full",  32'(ras_full),          32'(m_ras.size() == DEPTH));
    chk("ras_empty", 32'(ras_empty),         32'(m_ras.size() == 0));
    chk("ras_ovf",   32'(ras_ovf),           32'(m_ovf));
    chk("ras_unf",   32'(ras_unf),           32'(m_unf));
  endtask

  initial begin
    logic [5:0]  r_op;
    logic [31:0] bt, jt;
    m_pc = 32'h0; m_ovf = 1'b0; m_unf = 1'b0;
    reset = 1'b1; stall = 1'b0; valid = 1'b0; op = '0;
    zero = 1'b0; bgt = 1'b0; blt = 1'b0; branch_target = '0; jump_target = '0;

    // Reset, then sequential fetch.
    step(1, 0, 0, 6'h00, 0, 0, 0, 32'h0, 32'h0);
    chk("reset_pc", pc, RST_PC);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 6'h00, 0, 0, 0, 32'h0, 32'h0);
    chk("seq_pc12", pc, 32'hC);

    // beq taken and not taken.
    step(0, 0, 1, OP_BEQ, 1, 0, 0, 32'h100, 32'h0);
    chk("beq_taken", pc, 32'h100);
    step(0, 0, 1, OP_BEQ, 0, 0, 0, 32'h100, 32'h0);
    chk("beq_not_taken", pc, 32'h104);

    // Call from 0x40 then return.
    step(0, 0, 1, OP_JMP, 0, 0, 0, 32'h0, 32'h40);
    step(0, 0, 1, OP_CALL, 0, 0, 0, 32'h0, 32'h200);
    chk("call_pc", pc, 32'h200);
    step(0, 0, 1, OP_RET, 0, 0, 0, 32'h0, 32'h0);
    chk("ret_pc", pc, 32'h44);

    // Nine nested calls overflow, nine rets drain then underflow.
    for (int i = 0; i < 9; i++)
      step(0, 0, 1, OP_CALL, 0, 0, 0, 32'h0, 32'h1000 + 32'(i) * 32'h100);
    chk("ovf_after_9", 32'(ras_ovf), 32'h1);
    for (int i = 0; i < 9; i++) step(0, 0, 1, OP_RET, 0, 0, 0, 32'h0, 32'h0);
    chk("unf_after_9", 32'(ras_unf), 32'h1);

    // Stalled call holds, then proceeds.
    step(0, 1, 1, OP_CALL, 0, 0, 0, 32'h0, 32'h300);
    step(0, 0, 1, OP_CALL, 0, 0, 0, 32'h0, 32'h300);
    chk("unstalled_call", pc, 32'h300);

    // Reset beats a stalled call.
    step(1, 1, 1, OP_CALL, 0, 0, 0, 32'h0, 32'h500);
    chk("reset_over_call", 32'(ras_count), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(9))
        0: r_op = OP_BGT;
        1: r_op = OP_BLT;
        2: r_op = OP_BEQ;
        3: r_op = OP_BNE;
        4: r_op = OP_JMP;
        5, 6: r_op = OP_CALL;
        7, 8: r_op = OP_RET;
        default: r_op = 6'($urandom);
      endcase
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(9) != 0),
           r_op, 1'($urandom), 1'($urandom), 1'($urandom), bt, jt);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
